// File: rtl/codificador_controle_if.sv
// Board-button and command bus between the player-side encoder and its environment.
interface codificador_controle_if;
  logic       botao_cima;
  logic       botao_baixo;
  logic       botao_iniciar;
  logic       consumido;
  logic [1:0] controle;
  logic       iniciar;
  logic       comando_pendente;
  logic [3:0] db_estado;

  modport master (
    output botao_cima, botao_baixo, botao_iniciar, consumido,
    input  controle, iniciar, comando_pendente, db_estado
  );

  modport slave (
    input  botao_cima, botao_baixo, botao_iniciar, consumido,
    output controle, iniciar, comando_pendente, db_estado
  );
endinterface

// File: rtl/codificador_controle.sv
// Button conditioning (2-FF sync + debounce) and movement-command encoder for the
// drone simulator; a command is held until the datapath acknowledges it.

module cc_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic nivel,
  output logic evento
);
  localparam logic [CNT_W-1:0] LIMITE = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // evento is raised on the same edge the level rises, so the FSM sees it one edge later
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync   <= '0;
      cnt    <= '0;
      nivel  <= 1'b0;
      evento <= 1'b0;
    end else begin
      sync   <= {sync[0], raw};
      evento <= 1'b0;
      if (sync[1] != nivel) begin
        if (cnt == LIMITE) begin
          nivel  <= sync[1];
          evento <= sync[1];
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module codificador_controle #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  codificador_controle_if.slave  bus
);
  localparam int NUM_LANES = 3;
  localparam int CIMA = 0, BAIXO = 1, INI = 2;

  typedef enum logic [3:0] {
    OCIOSO   = 4'b0000,
    PENDENTE = 4'b0001,
    CONFLITO = 4'b0010
  } estado_t;

  logic [NUM_LANES-1:0] raw, nivel, evento;

  assign raw = {bus.botao_iniciar, bus.botao_baixo, bus.botao_cima};

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      cc_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_lane (
        .clock  (clock),
        .reset  (reset),
        .raw    (raw[i]),
        .nivel  (nivel[i]),
        .evento (evento[i])
      );
    end
  endgenerate

  estado_t    estado, prox;
  logic [1:0] controle_q, controle_n;
  logic       iniciar_q, pendente_q;
  logic       so_cima, so_baixo;

  assign so_cima  = evento[CIMA]  & ~evento[BAIXO];
  assign so_baixo = evento[BAIXO] & ~evento[CIMA];

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado     <= OCIOSO;
      controle_q <= 2'b00;
      iniciar_q  <= 1'b0;
      pendente_q <= 1'b0;
    end else begin
      estado     <= prox;
      controle_q <= controle_n;
      iniciar_q  <= evento[INI];
      pendente_q <= (prox == PENDENTE);
    end
  end

  // Conflict detection outranks start; start outranks movement events.
  always_comb begin
    prox       = estado;
    controle_n = controle_q;
    case (estado)
      CONFLITO: begin
        controle_n = 2'b00;
        if (!nivel[CIMA] && !nivel[BAIXO]) prox = OCIOSO;
      end
      OCIOSO, PENDENTE: begin
        if (nivel[CIMA] && nivel[BAIXO]) begin
          prox       = CONFLITO;
          controle_n = 2'b00;
        end else if (evento[INI]) begin
          prox       = OCIOSO;
          controle_n = 2'b00;
        end else if (estado == OCIOSO) begin
          controle_n = 2'b00;
          if (so_cima) begin
            prox       = PENDENTE;
            controle_n = 2'b01;
          end else if (so_baixo) begin
            prox       = PENDENTE;
            controle_n = 2'b10;
          end
        end else if (bus.consumido) begin
          if (so_cima) begin
            controle_n = 2'b01;
          end else if (so_baixo) begin
            controle_n = 2'b10;
          end else begin
            prox       = OCIOSO;
            controle_n = 2'b00;
          end
        end
      end
      default: begin
        prox       = OCIOSO;
        controle_n = 2'b00;
      end
    endcase
  end

  assign bus.controle         = controle_q;
  assign bus.iniciar          = iniciar_q;
  assign bus.comando_pendente = pendente_q;
  assign bus.db_estado        = estado;
endmodule

// File: tb/tb_codificador_controle.sv
// Randomized and directed check of codificador_controle against a cycle-level model.
module tb_codificador_controle;
  localparam int D = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  codificador_controle_if bus ();

  codificador_controle #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model state: raw samples from one and two edges back, debounced levels,
  // run lengths of disagreement, press pulses, and command mode (0 idle, 1 pending, 2 conflict).
  bit [2:0] r1, r2, lvl, ev;
  int       run [3];
  int       mode, cmd;
  bit       m_ini;

  task automatic model_step();
    bit [2:0] raw_now;
    raw_now = {bus.botao_iniciar, bus.botao_baixo, bus.botao_cima};
    if (!reset) begin
      r1 = '0; r2 = '0; lvl = '0; ev = '0;
      for (int b = 0; b < 3; b++) run[b] = 0;
      mode = 0; cmd = 0; m_ini = 0;
      return;
    end
    m_ini = ev[2];
    if (mode == 2) begin
      cmd = 0;
      if (lvl[0] == 0 && lvl[1] == 0) mode = 0;
    end else if (lvl[0] && lvl[1]) begin
      mode = 2; cmd = 0;
    end else if (ev[2]) begin
      mode = 0; cmd = 0;
    end else if (mode == 0) begin
      if (ev[0] && !ev[1]) begin mode = 1; cmd = 1; end
      else if (ev[1] && !ev[0]) begin mode = 1; cmd = 2; end
    end else if (bus.consumido) begin
      if (ev[0] && !ev[1]) cmd = 1;
      else if (ev[1] && !ev[0]) cmd = 2;
      else begin mode = 0; cmd = 0; end
    end
    // A level changes after D consecutive disagreeing synchronized samples.
    for (int b = 0; b < 3; b++) begin
      ev[b] = 0;
      if (r2[b] != lvl[b]) begin
        run[b]++;
        if (run[b] == D) begin
          lvl[b] = r2[b];
          ev[b]  = r2[b];
          run[b] = 0;
        end
      end else begin
        run[b] = 0;
      end
    end
    r2 = r1;
    r1 = raw_now;
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
    chk("controle", int'(bus.controle), cmd);
    chk("iniciar", int'(bus.iniciar), int'(m_ini));
    chk("pendente", int'(bus.comando_pendente), (mode == 1) ? 1 : 0);
    chk("db_estado", int'(bus.db_estado), mode);
  endtask

  initial begin
    int n;
    bus.botao_cima = 1; bus.botao_baixo = 1; bus.botao_iniciar = 1; bus.consumido = 0;
    reset = 0;
    // reset with all buttons high
    step(); step();
    chk("rst_controle", int'(bus.controle), 0);
    chk("rst_estado", int'(bus.db_estado), 0);
    bus.botao_cima = 0; bus.botao_baixo = 0; bus.botao_iniciar = 0;
    reset = 1;
    repeat (4) step();

    // clean press and latency
    bus.botao_cima = 1;
    n = 0;
    while (bus.controle != 2'b01 && n < 20) begin step(); n++; end
    chk("lat_cima", n, D + 3);
    chk("pend_cima", int'(bus.comando_pendente), 1);
    repeat (4) step();
    bus.consumido = 1; step(); bus.consumido = 0;
    chk("ack_controle", int'(bus.controle), 0);
    chk("ack_estado", int'(bus.db_estado), 0);
    repeat (10) step();
    chk("held_no_repeat", int'(bus.controle), 0);
    bus.botao_cima = 0;
    repeat (8) step();

    // bounce
    for (int i = 0; i < 4; i++) begin bus.botao_baixo = (i % 2 == 0); step(); end
    bus.botao_baixo = 0;
    repeat (8) step();
    chk("bounce", int'(bus.controle), 0);
    bus.botao_baixo = 1; repeat (3) step(); bus.botao_baixo = 0;
    repeat (8) step();
    chk("short_press", int'(bus.controle), 0);

    // first-come, then swap on ack
    bus.botao_cima = 1; repeat (7) step(); bus.botao_cima = 0;
    repeat (8) step();
    chk("pend01", int'(bus.controle), 1);
    bus.botao_baixo = 1; repeat (8) step();
    chk("first_come", int'(bus.controle), 1);
    bus.botao_baixo = 0; repeat (8) step();
    bus.botao_baixo = 1; repeat (D + 2) step();
    bus.consumido = 1; step(); bus.consumido = 0;
    chk("swap_controle", int'(bus.controle), 2);
    chk("swap_estado", int'(bus.db_estado), 1);

    // start override while pending 10
    bus.botao_iniciar = 1;
    repeat (D + 2) step();
    chk("ini_early", int'(bus.iniciar), 0);
    step();
    chk("ini_pulse", int'(bus.iniciar), 1);
    chk("ini_controle", int'(bus.controle), 0);
    chk("ini_estado", int'(bus.db_estado), 0);
    step();
    chk("ini_one_cycle", int'(bus.iniciar), 0);
    bus.botao_iniciar = 0; bus.botao_baixo = 0;
    repeat (8) step();

    // conflict
    bus.botao_cima = 1; bus.botao_baixo = 1; repeat (8) step();
    chk("conf_estado", int'(bus.db_estado), 2);
    chk("conf_controle", int'(bus.controle), 0);
    bus.botao_cima = 0; repeat (8) step();
    chk("conf_hold", int'(bus.db_estado), 2);
    bus.botao_baixo = 0; repeat (8) step();
    chk("conf_exit", int'(bus.db_estado), 0);
    chk("conf_no_cmd", int'(bus.controle), 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom % 400 != 0);
      if ($urandom % 6 == 0) bus.botao_cima = ~bus.botao_cima;
      if ($urandom % 6 == 0) bus.botao_baixo = ~bus.botao_baixo;
      if ($urandom % 20 == 0) bus.botao_iniciar = ~bus.botao_iniciar;
      bus.consumido = ($urandom % 4 == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
